// File: rtl/ir_tx_if.sv
// ir_tx_if: request/response bundle between the button logic and the IR
// frame encoder.
//   send, b_power, b_blue, b_yellow, b_green, b_red : request side (master drives)
//   irda, code, busy, done                          : encoder status (slave drives)
interface ir_tx_if;
    logic       send;
    logic       b_power;
    logic       b_blue;
    logic       b_yellow;
    logic       b_green;
    logic       b_red;
    logic       irda;
    logic [2:0] code;
    logic       busy;
    logic       done;

    modport master (
        output send, b_power, b_blue, b_yellow, b_green, b_red,
        input  irda, code, busy, done
    );

    modport slave (
        input  send, b_power, b_blue, b_yellow, b_green, b_red,
        output irda, code, busy, done
    );
endinterface

// File: rtl/ir_transmitter.sv
// ir_transmitter: serialises one button press into an IR frame on irda.
// The frame is a low start bit, then the 3-bit button code MSB first, then a
// high guard interval. The line idles high.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active low
//   tx   : ir_tx_if.slave
//          send + b_* in (sampled in IDLE only)
//          irda / code / busy / done out (all registered)
// Parameters:
//   BIT_CYCLES   : cycles per start/data bit (>= 4)
//   GUARD_CYCLES : high cycles after bit 0 before done (>= 1)
module ir_transmitter #(
    parameter int BIT_CYCLES   = 12,
    parameter int GUARD_CYCLES = 24
) (
    input  logic     clk,
    input  logic     rst,
    ir_tx_if.slave   tx
);

    localparam int MAX_CYCLES = (BIT_CYCLES > GUARD_CYCLES) ? BIT_CYCLES : GUARD_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES);

    // Reload with count-1 so that each state lasts exactly its parameter count.
    localparam logic [CW-1:0] BIT_RELOAD   = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_RELOAD = CW'(GUARD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT2,
        BIT1,
        BIT0,
        GUARD
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          irda_q;
    logic [2:0]    code_q;
    logic          busy_q;
    logic          done_q;

    // Button priority encoder: power > blue > yellow > green > red.
    logic [2:0] code_d;
    logic       req_valid;

    always_comb begin
        code_d    = 3'b000;
        req_valid = 1'b1;
        if (tx.b_power)       code_d = 3'b001;
        else if (tx.b_blue)   code_d = 3'b100;
        else if (tx.b_yellow) code_d = 3'b110;
        else if (tx.b_green)  code_d = 3'b010;
        else if (tx.b_red)    code_d = 3'b011;
        else                  req_valid = 1'b0;
    end

    logic cnt_zero;
    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            irda_q  <= 1'b1;
            code_q  <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    irda_q <= 1'b1;
                    // IDLE includes the done cycle, so back-to-back sends land here.
                    if (tx.send && req_valid) begin
                        state_q <= START;
                        cnt_q   <= BIT_RELOAD;
                        irda_q  <= 1'b0;
                        code_q  <= code_d;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_zero) begin
                        state_q <= BIT2;
                        cnt_q   <= BIT_RELOAD;
                        irda_q  <= code_q[2];
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                BIT2: begin
                    if (cnt_zero) begin
                        state_q <= BIT1;
                        cnt_q   <= BIT_RELOAD;
                        irda_q  <= code_q[1];
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                BIT1: begin
                    if (cnt_zero) begin
                        state_q <= BIT0;
                        cnt_q   <= BIT_RELOAD;
                        irda_q  <= code_q[0];
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                BIT0: begin
                    if (cnt_zero) begin
                        state_q <= GUARD;
                        cnt_q   <= GUARD_RELOAD;
                        irda_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                GUARD: begin
                    if (cnt_zero) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    irda_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx.irda = irda_q;
    assign tx.code = code_q;
    assign tx.busy = busy_q;
    assign tx.done = done_q;

endmodule

// File: tb/tb_ir_transmitter.sv
// tb_ir_transmitter: self-checking bench for ir_transmitter at default timing.
// Expected line/status per cycle comes from a frame-level model: the frame is
// a sequence of symbols (start, b2, b1, b0) of BITC cycles each plus a guard.
module tb_ir_transmitter;

    localparam int BITC   = 12;
    localparam int GUARDC = 24;
    localparam int FRAME  = 4 * BITC + GUARDC;
    localparam int CAPN   = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ir_tx_if tx();

    ir_transmitter #(
        .BIT_CYCLES   (BITC),
        .GUARD_CYCLES (GUARDC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .tx  (tx)
    );

    int passed = 0;
    int total  = 0;
    logic [2:0] last_code = 3'b000;

    // Per-cycle observation: {irda, busy, done, code}
    logic [5:0] cap [CAPN];

    // Buttons packed as {power, blue, yellow, green, red}.
    function automatic logic [2:0] ref_code(input logic [4:0] b);
        logic [2:0] tbl [5] = '{3'b011, 3'b010, 3'b110, 3'b100, 3'b001};
        ref_code = 3'b000;
        for (int i = 0; i < 5; i++)
            if (b[i]) ref_code = tbl[i];
    endfunction

    function automatic logic exp_line(input logic [2:0] c, input int j);
        int sym;
        sym = j / BITC;
        if (j >= 4 * BITC) return 1'b1;
        if (sym == 0)      return 1'b0;
        return c[3 - sym];
    endfunction

    // Expected observation j cycles after the accepting edge of a frame of code c.
    function automatic logic [5:0] exp_vec(input logic [2:0] c, input int j);
        if (j < FRAME)       return {exp_line(c, j), 1'b1, 1'b0, c};
        else if (j == FRAME) return {1'b1, 1'b0, 1'b1, c};
        else                 return {1'b1, 1'b0, 1'b0, c};
    endfunction

    task automatic set_btn(input logic [4:0] b);
        {tx.b_power, tx.b_blue, tx.b_yellow, tx.b_green, tx.b_red} = b;
    endtask

    // Present a request for exactly one rising edge.
    task automatic launch(input logic [4:0] b);
        tx.send = 1'b1;
        set_btn(b);
        @(posedge clk);
        #1;
        tx.send = 1'b0;
        set_btn(5'b0);
    endtask

    // Record n cycles at the falling edge; optionally inject a one-edge request
    // right after sample inj_at.
    task automatic capture(input int n, input int inj_at, input logic [4:0] inj);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            cap[j] = {tx.irda, tx.busy, tx.done, tx.code};
            if (j == inj_at) begin
                tx.send = 1'b1;
                set_btn(inj);
            end else if (j == inj_at + 1) begin
                tx.send = 1'b0;
                set_btn(5'b0);
            end
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #2;
        total++;
        if ({tx.irda, tx.busy, tx.done, tx.code} !== 6'b100000)
            $display("FAIL reset_async: got %b want %b", {tx.irda, tx.busy, tx.done, tx.code}, 6'b100000);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        capture(20, -1, 5'b0);
        for (int j = 0; j < 20; j++) begin
            total++;
            if (cap[j] !== 6'b100000)
                $display("FAIL reset_idle cyc %0d: got %b want %b", j, cap[j], 6'b100000);
            else passed++;
        end
    endtask

    task automatic test_single_blue();
        launch(5'b01000);
        capture(FRAME + 3, -1, 5'b0);
        for (int j = 0; j < FRAME + 3; j++) begin
            total++;
            if (cap[j] !== exp_vec(3'b100, j))
                $display("FAIL blue_frame cyc %0d: got %b want %b", j, cap[j], exp_vec(3'b100, j));
            else passed++;
        end
        last_code = 3'b100;
    endtask

    task automatic test_priority_and_ignore();
        int dones;
        dones = 0;
        launch(5'b10001);
        capture(FRAME + 8, 29, 5'b00010);
        for (int j = 0; j < FRAME + 8; j++) begin
            dones += int'(cap[j][3]);
            total++;
            if (cap[j] !== exp_vec(3'b001, j))
                $display("FAIL prio_frame cyc %0d: got %b want %b", j, cap[j], exp_vec(3'b001, j));
            else passed++;
        end
        total++;
        if (dones !== 1)
            $display("FAIL prio_done_count: got %0d want 1", dones);
        else passed++;
        last_code = 3'b001;
    endtask

    task automatic test_back_to_back();
        logic [5:0] e;
        launch(5'b00100);
        capture(2 * FRAME + 3, FRAME, 5'b00001);
        for (int j = 0; j < 2 * FRAME + 3; j++) begin
            e = (j <= FRAME) ? exp_vec(3'b110, j) : exp_vec(3'b011, j - FRAME - 1);
            total++;
            if (cap[j] !== e)
                $display("FAIL b2b_frame cyc %0d: got %b want %b", j, cap[j], e);
            else passed++;
        end
        last_code = 3'b011;
    endtask

    task automatic test_no_button();
        launch(5'b00000);
        capture(10, -1, 5'b0);
        for (int j = 0; j < 10; j++) begin
            total++;
            if (cap[j] !== {3'b100, last_code})
                $display("FAIL nobtn cyc %0d: got %b want %b", j, cap[j], {3'b100, last_code});
            else passed++;
        end
    endtask

    task automatic test_mid_reset();
        launch(5'b00010);
        capture(30, -1, 5'b0);
        for (int j = 0; j < 30; j++) begin
            total++;
            if (cap[j] !== exp_vec(3'b010, j))
                $display("FAIL green_pre cyc %0d: got %b want %b", j, cap[j], exp_vec(3'b010, j));
            else passed++;
        end
        // Inside BIT1 (data 1); reset must drop the line high before any edge.
        #2 rst = 1'b0;
        #1;
        total++;
        if ({tx.irda, tx.busy, tx.done, tx.code} !== 6'b100000)
            $display("FAIL midreset_async: got %b want %b", {tx.irda, tx.busy, tx.done, tx.code}, 6'b100000);
        else passed++;
        @(negedge clk);
        total++;
        if ({tx.irda, tx.busy, tx.done, tx.code} !== 6'b100000)
            $display("FAIL midreset_hold: got %b want %b", {tx.irda, tx.busy, tx.done, tx.code}, 6'b100000);
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        launch(5'b10000);
        capture(FRAME + 2, -1, 5'b0);
        for (int j = 0; j < FRAME + 2; j++) begin
            total++;
            if (cap[j] !== exp_vec(3'b001, j))
                $display("FAIL post_reset_power cyc %0d: got %b want %b", j, cap[j], exp_vec(3'b001, j));
            else passed++;
        end
        last_code = 3'b001;
    endtask

    task automatic test_random();
        logic [4:0] b;
        logic [2:0] c;
        for (int k = 0; k < 10; k++) begin
            b = 5'($urandom_range(0, 31));
            c = ref_code(b);
            launch(b);
            if (b == 5'b0) begin
                capture(5, -1, 5'b0);
                for (int j = 0; j < 5; j++) begin
                    total++;
                    if (cap[j] !== {3'b100, last_code})
                        $display("FAIL rand_idle k%0d cyc %0d: got %b want %b", k, j, cap[j], {3'b100, last_code});
                    else passed++;
                end
            end else begin
                capture(FRAME + 2, -1, 5'b0);
                for (int j = 0; j < FRAME + 2; j++) begin
                    total++;
                    if (cap[j] !== exp_vec(c, j))
                        $display("FAIL rand_frame k%0d btn %b cyc %0d: got %b want %b", k, b, j, cap[j], exp_vec(c, j));
                    else passed++;
                end
                last_code = c;
            end
        end
    endtask

    initial begin
        tx.send = 1'b0;
        set_btn(5'b0);
        test_reset();
        test_single_blue();
        test_priority_and_ignore();
        test_back_to_back();
        test_no_button();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ir_transmitter.md
# ir_transmitter

Encodes a single button press into the serial IR frame format understood by the game's IR receive FSM. It drives the `irda` line: idle-high, one low start bit, then a 3-bit button code MSB first, then a high guard interval. It sits between the local button/keypad logic and the IR emitter driver, and serves as the loopback stimulus source for receiver testing.

## Interface
- `BIT_CYCLES`, default 12: clock cycles per start/data bit; must be ≥ 4.
- `GUARD_CYCLES`, default 24: minimum high cycles after bit 0 before the frame completes; must be ≥ 1.
- `clk` in 1: the only clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `send` in 1: request strobe, sampled on the rising edge in IDLE only.
- `b_power`, `b_blue`, `b_yellow`, `b_green`, `b_red` in 1 each: button selects, sampled together with `send`.
- `irda` out 1: registered serial IR line; idle level is 1.
- `code` out 3: latched code of the frame in flight; holds the last code after completion.
- `busy` out 1: high from the first start-bit cycle through the last guard cycle.
- `done` out 1: one-cycle pulse marking frame completion.

## Operation
- Code map: power=001, blue=100, yellow=110, green=010, red=011.
- Priority when several buttons are high: power > blue > yellow > green > red.
- `send`=1 in IDLE with no button high: ignored. No frame is sent and no output changes.
- `send` while busy: ignored. No queueing.
- The code is latched at acceptance. Button inputs are don't-care during the frame.
- FSM states: IDLE, START, BIT2, BIT1, BIT0, GUARD.
  - IDLE: `irda`=1.
  - IDLE → START on a valid request.
  - START: `irda`=0 for BIT_CYCLES.
  - BIT2, BIT1, BIT0: `irda`=`code[2]`, `code[1]`, `code[0]` respectively, each for BIT_CYCLES.
  - GUARD: `irda`=1 for GUARD_CYCLES, then → IDLE.
- A single down-counter is reloaded on every state entry. Its width is clog2(max(BIT_CYCLES, GUARD_CYCLES)).
- Each state lasts exactly its parameter count. There is no off-by-one.
- Reset, including mid-frame: `irda`=1, `busy`=0, `done`=0, `code`=000, state IDLE, counter 0. Takes effect asynchronously; the line must never stay low after reset assertion.
- Reset release: the first edge after `rst` rises may accept `send`.

## Timing
- `send` accepted at edge N. At edge N+1: `irda` goes 0, `busy` goes 1, `code` is valid.
- Start bit occupies cycles N+1 … N+BIT_CYCLES.
- Bit k (k=2,1,0) occupies N+1+(3−k)·BIT_CYCLES … N+(4−k)·BIT_CYCLES.
- Guard occupies N+1+4·BIT_CYCLES … N+4·BIT_CYCLES+GUARD_CYCLES.
- At edge N+1+4·BIT_CYCLES+GUARD_CYCLES: `busy` goes 0 and `done` goes 1 for one cycle. The state is IDLE in that cycle.
- `send` in the `done` cycle is accepted: back-to-back frames are legal.
- Total frame length is 4·BIT_CYCLES+GUARD_CYCLES cycles; 72 at defaults.
- Sampling margin at defaults: a receiver that detects the start edge and samples about 13, 26 and 37 cycles later lands inside bits 2, 1 and 0, with at least 1 cycle of margin to each edge.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset, then hold `rst`=1 with no request for 20 cycles.
  - Required: `irda`=1, `busy`=0, `done`=0, `code`=000 throughout.
- `send`+`b_blue` at cycle 0, defaults.
  - `irda`: 0 for cycles 1–12, 1 for 13–24, 0 for 25–48, 1 for 49–72.
  - `code`=100, `busy`=1 for cycles 1–72, `done`=1 at cycle 73 only.
- `send` with `b_red`+`b_power` both high.
  - `code`=001; data bits on `irda` are 0, 0, 1.
  - Second `send`+`b_green` at cycle 30 is ignored: `code` stays 001 and exactly one `done` pulse occurs.
- Frame `b_yellow` (110), then `send`+`b_red` in the `done` cycle.
  - Second start bit begins the next cycle with no idle gap.
  - Second frame carries 011.
- `send` with no button high.
  - `busy` stays 0 and `irda` stays 1.
- `rst` low mid-BIT1 of a `b_green` frame.
  - `irda`=1 and `busy`=0 within the same cycle.
  - After release, a new `send`+`b_power` produces a clean 001 frame.
